spi_linebuf_reader: RTL and testbench

SPI slave that reads captured pixel words out of the 4096 x 16-bit line buffer and shifts them to an external host. It drives the buffer's read port (`rdaddr`/`rddata`), which the pixel-copy path fills through the write port. All SPI pins are asynchronous to `clk` and are oversampled in the `clk` domain.

---
 rtl/spi_linebuf_reader_if.sv | 25 ++
 rtl/spi_linebuf_reader.sv | 180 ++++++++++++++++++
 tb/tb_spi_linebuf_reader.sv | 162 ++++++++++++++++
 3 files changed

// File: rtl/spi_linebuf_reader_if.sv
// rtl/spi_linebuf_reader_if.sv - SPI pins and line-buffer read port of the line-buffer reader
`timescale 1ns/1ps
interface spi_linebuf_reader_if #(
    parameter int ADDR_W = 12,
    parameter int DATA_W = 16
) ();
    logic              spi_clk;
    logic              cs;
    logic              spi_mosi;
    logic              spi_miso;
    logic              capture_busy;
    logic [ADDR_W-1:0] rdaddr;
    logic [DATA_W-1:0] rddata;
    logic              xfer_active;

    modport slave (
        input  spi_clk, cs, spi_mosi, capture_busy, rddata,
        output spi_miso, rdaddr, xfer_active
    );

    modport master (
        output spi_clk, cs, spi_mosi, capture_busy, rddata,
        input  spi_miso, rdaddr, xfer_active
    );
endinterface

// File: rtl/spi_linebuf_reader.sv
// rtl/spi_linebuf_reader.sv - mode-0 SPI slave streaming line-buffer words to a host
`timescale 1ns/1ps
module spi_linebuf_reader #(
    parameter int ADDR_W = 12,
    parameter int DATA_W = 16,
    parameter int RD_LAT = 2
) (
    input  logic                  clk,
    input  logic                  res,
    spi_linebuf_reader_if.slave   bus
);
    localparam int WW = $clog2(RD_LAT + 2);
    localparam logic [WW-1:0] LAT1 = WW'(RD_LAT + 1);
    localparam logic [4:0] WORD_LAST = 5'(DATA_W - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_CMD, S_ADDR, S_FETCH, S_DATA, S_STATUS, S_SINK
    } state_t;

    // [0],[1] synchroniser, [2] edge-detect history
    logic [2:0] sclk_q, cs_q, mosi_q;

    state_t            state_q, state_d;
    logic [4:0]        bitcnt_q, bitcnt_d;
    logic [ADDR_W-2:0] in_q, in_d;
    logic [DATA_W-1:0] sh_q, sh_d;
    logic [DATA_W-1:0] next_q, next_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [WW-1:0]     wait_q, wait_d;
    logic              miso_q, miso_d;
    logic              xfer_q, xfer_d;

    logic              sclk_rise, sclk_fall, cs_fall, cs_rise, fetch_done;
    logic [ADDR_W-1:0] shift_in;

    always_ff @(posedge clk or posedge res) begin
        if (res) begin
            sclk_q <= 3'b000;
            cs_q   <= 3'b111;
            mosi_q <= 3'b000;
        end else begin
            sclk_q <= {sclk_q[1:0], bus.spi_clk};
            cs_q   <= {cs_q[1:0], bus.cs};
            mosi_q <= {mosi_q[1:0], bus.spi_mosi};
        end
    end

    assign sclk_rise  = sclk_q[1] & ~sclk_q[2] & ~cs_q[1];
    assign sclk_fall  = ~sclk_q[1] & sclk_q[2] & ~cs_q[1];
    assign cs_fall    = ~cs_q[1] & cs_q[2];
    assign cs_rise    = cs_q[1] & ~cs_q[2];
    assign shift_in   = {in_q, mosi_q[2]};
    assign fetch_done = (wait_q == WW'(1));

    always_ff @(posedge clk or posedge res) begin
        if (res) begin
            state_q  <= S_IDLE;
            bitcnt_q <= '0;
            in_q     <= '0;
            sh_q     <= '0;
            next_q   <= '0;
            addr_q   <= '0;
            wait_q   <= '0;
            miso_q   <= 1'b0;
            xfer_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            bitcnt_q <= bitcnt_d;
            in_q     <= in_d;
            sh_q     <= sh_d;
            next_q   <= next_d;
            addr_q   <= addr_d;
            wait_q   <= wait_d;
            miso_q   <= miso_d;
            xfer_q   <= xfer_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        bitcnt_d = bitcnt_q;
        in_d     = in_q;
        sh_d     = sh_q;
        next_d   = next_q;
        addr_d   = addr_q;
        wait_d   = (wait_q != '0) ? wait_q - WW'(1) : '0;
        xfer_d   = xfer_q;

        case (state_q)
            S_IDLE: begin
                if (cs_fall) begin
                    state_d  = S_CMD;
                    bitcnt_d = '0;
                end
            end
            S_CMD: begin
                if (sclk_rise) begin
                    in_d = shift_in[ADDR_W-2:0];
                    if (bitcnt_q == 5'd7) begin
                        bitcnt_d = '0;
                        case (shift_in[7:0])
                            8'h03:   state_d = S_ADDR;
                            8'h05: begin
                                sh_d = '0;
                                sh_d[DATA_W-1 -: 8] = {bus.capture_busy, 6'b0, 1'b1};
                                state_d = S_STATUS;
                            end
                            default: state_d = S_SINK;
                        endcase
                    end else begin
                        bitcnt_d = bitcnt_q + 5'd1;
                    end
                end
            end
            S_ADDR: begin
                // Only the last ADDR_W bits survive in the shifter, so upper address bits fall away
                if (sclk_rise) begin
                    in_d = shift_in[ADDR_W-2:0];
                    if (bitcnt_q == 5'd15) begin
                        bitcnt_d = '0;
                        addr_d   = shift_in;
                        wait_d   = LAT1;
                        state_d  = S_FETCH;
                    end else begin
                        bitcnt_d = bitcnt_q + 5'd1;
                    end
                end
            end
            S_FETCH: begin
                if (fetch_done) begin
                    sh_d    = bus.rddata;
                    addr_d  = addr_q + ADDR_W'(1);
                    wait_d  = LAT1;
                    state_d = S_DATA;
                end
            end
            S_DATA: begin
                if (fetch_done)
                    next_d = bus.rddata;
                // bitcnt==0 marks the falling edge that closes a word: hold the fresh MSB
                if (sclk_rise) begin
                    if (bitcnt_q == WORD_LAST) begin
                        bitcnt_d = '0;
                        sh_d     = next_q;
                        addr_d   = addr_q + ADDR_W'(1);
                        wait_d   = LAT1;
                    end else begin
                        bitcnt_d = bitcnt_q + 5'd1;
                    end
                end else if (sclk_fall && bitcnt_q != '0) begin
                    sh_d = sh_q << 1;
                end
            end
            S_STATUS: begin
                if (sclk_rise)
                    bitcnt_d = 5'd1;
                else if (sclk_fall && bitcnt_q != '0)
                    sh_d = sh_q << 1;
            end
            S_SINK: begin
            end
            default: state_d = S_IDLE;
        endcase

        if (cs_fall)
            xfer_d = 1'b1;
        if (cs_rise) begin
            xfer_d   = 1'b0;
            state_d  = S_IDLE;
            bitcnt_d = '0;
            wait_d   = '0;
        end

        miso_d = ((state_d == S_DATA) || (state_d == S_STATUS)) ? sh_d[DATA_W-1] : 1'b0;
    end

    assign bus.spi_miso    = miso_q;
    assign bus.rdaddr      = addr_q;
    assign bus.xfer_active = xfer_q;
endmodule

// File: tb/tb_spi_linebuf_reader.sv
// tb/tb_spi_linebuf_reader.sv - directed bench for spi_linebuf_reader
`timescale 1ns/1ps
module tb_spi_linebuf_reader;
    logic clk = 1'b0;
    logic res;
    int   nvec  = 0;
    int   nfail = 0;
    int   half  = 60;
    int   phase = 2;
    logic [63:0] rx;
    logic [15:0] p0, p1;

    spi_linebuf_reader_if #(.ADDR_W(12), .DATA_W(16)) bus ();

    spi_linebuf_reader #(.ADDR_W(12), .DATA_W(16), .RD_LAT(2)) dut (
        .clk (clk),
        .res (res),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Line buffer holding 0xA000+addr, two-cycle read pipeline
    always_ff @(posedge clk) begin
        p0 <= 16'hA000 + {4'h0, bus.rdaddr};
        p1 <= p0;
    end
    assign bus.rddata = p1;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        nvec++;
        if (got !== exp) begin
            nfail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic spi_xfer(input int n, input logic [63:0] tx, output logic [63:0] rxo);
        rxo = '0;
        for (int i = n - 1; i >= 0; i--) begin
            bus.spi_mosi = tx[i];
            #(half);
            bus.spi_clk = 1'b1;
            rxo = {rxo[62:0], bus.spi_miso};
            #(half);
            bus.spi_clk = 1'b0;
        end
    endtask

    task automatic cs_begin();
        @(posedge clk);
        #(phase);
        bus.cs = 1'b0;
        #(half);
    endtask

    task automatic cs_end();
        #(half);
        bus.cs = 1'b1;
        repeat (8) @(posedge clk);
    endtask

    task automatic read_burst(input logic [15:0] a, input int nbits, output logic [63:0] rxo);
        logic [63:0] dummy;
        cs_begin();
        spi_xfer(8, 64'h03, dummy);
        spi_xfer(16, {48'h0, a}, dummy);
        spi_xfer(nbits, 64'h0, rxo);
    endtask

    initial begin
        res = 1'b1;
        bus.spi_clk = 1'b0;
        bus.cs = 1'b1;
        bus.spi_mosi = 1'b0;
        bus.capture_busy = 1'b0;
        repeat (4) @(posedge clk);
        #2;
        check("rst_miso", 64'(bus.spi_miso), 64'd0);
        check("rst_rdaddr", 64'(bus.rdaddr), 64'd0);
        check("rst_xfer", 64'(bus.xfer_active), 64'd0);
        res = 1'b0;
        repeat (4) @(posedge clk);

        cs_begin();
        check("xfer_rise", 64'(bus.xfer_active), 64'd1);
        spi_xfer(8, 64'h03, rx);
        spi_xfer(16, 64'h0005, rx);
        spi_xfer(48, 64'h0, rx);
        check("burst_5", rx, 64'h0000_A005_A006_A007);
        cs_end();
        check("xfer_fall", 64'(bus.xfer_active), 64'd0);
        check("idle_miso", 64'(bus.spi_miso), 64'd0);

        read_burst(16'h0FFE, 48, rx);
        check("wrap", rx, 64'h0000_AFFE_AFFF_A000);
        cs_end();

        read_burst(16'h3007, 16, rx);
        check("addr_hi_ignored", rx, 64'hA007);
        cs_end();

        bus.capture_busy = 1'b1;
        cs_begin();
        spi_xfer(8, 64'h05, rx);
        spi_xfer(16, 64'h0, rx);
        check("status_busy", rx, 64'h8100);
        cs_end();
        bus.capture_busy = 1'b0;
        cs_begin();
        spi_xfer(8, 64'h05, rx);
        spi_xfer(16, 64'h0, rx);
        check("status_idle", rx, 64'h0100);
        cs_end();

        cs_begin();
        spi_xfer(8, 64'h42, rx);
        spi_xfer(32, 64'hFFFF_FFFF, rx);
        check("unknown_sink", rx, 64'h0);
        cs_end();
        read_burst(16'h0010, 16, rx);
        check("after_unknown", rx, 64'hA010);
        cs_end();

        read_burst(16'h00FF, 23, rx);
        check("abort_pre", rx, {41'h0, 16'hA0FF, 7'b1010000});
        #(half);
        check("abort_miso_hi", 64'(bus.spi_miso), 64'd1);
        bus.cs = 1'b1;
        repeat (4) @(posedge clk);
        #2;
        check("abort_miso", 64'(bus.spi_miso), 64'd0);
        check("abort_xfer", 64'(bus.xfer_active), 64'd0);
        repeat (6) @(posedge clk);
        read_burst(16'h0000, 16, rx);
        check("after_abort", rx, 64'hA000);
        cs_end();

        read_burst(16'h0005, 20, rx);
        #3;
        res = 1'b1;
        #1;
        check("res_miso", 64'(bus.spi_miso), 64'd0);
        check("res_rdaddr", 64'(bus.rdaddr), 64'd0);
        check("res_xfer", 64'(bus.xfer_active), 64'd0);
        bus.cs = 1'b1;
        #20;
        res = 1'b0;
        repeat (6) @(posedge clk);

        half = 40;
        for (int it = 0; it < 3; it++) begin
            phase = $urandom_range(1, 8);
            read_burst(16'h0005, 48, rx);
            check("burst_8to1", rx, 64'h0000_A005_A006_A007);
            cs_end();
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end
endmodule
